// File: rtl/ex_pkg.sv
// Shared ALU operation codes for the execute stage and the ALU decoder.
package ex_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/ex_stage_alu.sv
// Purely combinational integer ALU; unused operation codes yield zero.
module alu
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [SHAMT_W-1:0] shamt;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case statement can leave it unassigned (a latch).
        y     = '0;
        shamt = b[SHAMT_W-1:0];
        case (alu_ctrl)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, valid/ready pipeline register with
// flush, and a back-pressure cycle counter.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_y;
    logic            accept;
    logic            stalled;

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic [XLEN-1:0] rs2_q,       rs2_d;
    logic [4:0]      rd_q,        rd_d;
    logic [31:0]     stall_q,     stall_d;

    assign op_b = alu_src ? imm : rs2_data;

    alu #(.XLEN(XLEN)) u_alu (
        .alu_ctrl (alu_ctrl),
        .a        (rs1_data),
        .b        (op_b),
        .y        (alu_y)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stalled  = valid_q && !out_ready;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        result_d    = result_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        stall_d     = stalled ? stall_q + 32'd1 : stall_q;

        // Flush outranks both accept and drain; data registers are left as-is.
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            reg_write_d = reg_write && (rd_addr != 5'd0);
            result_d    = alu_y;
            rs2_d       = rs2_data;
            rd_d        = rd_addr;
        end else if (valid_q && out_ready) begin
            valid_d     = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset along with the control bits
    // because their zero values are visible on the outputs after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            result_q    <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            stall_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values regardless of statement order.
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            result_q    <= result_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_reg_write = reg_write_q;
    assign out_result    = result_q;
    assign out_rs2_data  = rs2_q;
    assign out_rd        = rd_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a cycle-level reference
// model of the handshake, flush, stall counter and ALU arithmetic.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] stall_cnt;

    ex_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_ctrl      (alu_ctrl),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .alu_src       (alu_src),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rs2_data  (out_rs2_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state: what the result register should hold.
    bit          m_valid;
    bit          m_rw;
    logic [31:0] m_result;
    logic [31:0] m_rs2;
    logic [4:0]  m_rd;
    logic [31:0] m_stall;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b & 32'd31;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a ^ b;
            3: return a | b;
            4: return a & b;
            5: return a << sh;
            6: return a >> sh;
            7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            8: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_rw     = 0;
        m_result = '0;
        m_rs2    = '0;
        m_rd     = '0;
        m_stall  = '0;
    endtask

    task automatic drive(input bit v, input int op, input logic [31:0] a, input logic [31:0] b2,
                         input logic [31:0] im, input bit src, input logic [4:0] rd,
                         input bit rw, input bit fl, input bit ordy);
        in_valid  = v;
        alu_ctrl  = 4'(op);
        rs1_data  = a;
        rs2_data  = b2;
        imm       = im;
        alu_src   = src;
        rd_addr   = rd;
        reg_write = rw;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        check({tag, ".out_reg_write"}, {31'b0, out_reg_write}, {31'b0, m_rw});
        check({tag, ".stall_cnt"}, stall_cnt, m_stall);
        if (m_valid) begin
            check({tag, ".out_result"}, out_result, m_result);
            check({tag, ".out_rs2_data"}, out_rs2_data, m_rs2);
            check({tag, ".out_rd"}, {27'b0, out_rd}, {27'b0, m_rd});
        end
    endtask

    // One clock: check in_ready, advance the model over the edge, compare.
    task automatic cycle(input string tag);
        bit          rdy, acc, n_valid, n_rw;
        logic [31:0] n_result, n_rs2, n_stall;
        logic [4:0]  n_rd;
        #1;
        rdy = !m_valid || out_ready;
        check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        acc      = in_valid && rdy && !flush;
        n_valid  = m_valid;
        n_rw     = m_rw;
        n_result = m_result;
        n_rs2    = m_rs2;
        n_rd     = m_rd;
        n_stall  = m_stall + ((m_valid && !out_ready) ? 32'd1 : 32'd0);
        if (flush) begin
            n_valid = 0;
            n_rw    = 0;
        end else if (acc) begin
            n_valid  = 1;
            n_rw     = reg_write && (rd_addr != 0);
            n_result = ref_alu(int'(alu_ctrl), rs1_data, alu_src ? imm : rs2_data);
            n_rs2    = rs2_data;
            n_rd     = rd_addr;
        end else if (m_valid && out_ready) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else begin
            m_valid  = n_valid;
            m_rw     = n_rw;
            m_result = n_result;
            m_rs2    = n_rs2;
            m_rd     = n_rd;
            m_stall  = n_stall;
        end
        compare_outputs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stall0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("reset");
        rst_n = 1'b1;

        // Negative immediate ADD, one-cycle latency.
        drive(1, ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1, 5'd3, 1, 0, 1);
        cycle("add_imm");
        check("add_imm.result_const", out_result, 32'd2);
        check("add_imm.valid_const", {31'b0, out_valid}, 32'd1);

        // Shifts and set-less-than corner operands.
        drive(1, ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 0, 5'd4, 1, 0, 1);
        cycle("sra");
        check("sra.const", out_result, 32'hF800_0000);
        drive(1, ALU_SRL, 32'h8000_0000, 32'd4, 32'd0, 0, 5'd4, 1, 0, 1);
        cycle("srl");
        check("srl.const", out_result, 32'h0800_0000);
        drive(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd5, 1, 0, 1);
        cycle("slt");
        check("slt.const", out_result, 32'd1);
        drive(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd5, 1, 0, 1);
        cycle("sltu");
        check("sltu.const", out_result, 32'd0);

        // x0 destination never writes; unused opcode yields zero.
        drive(1, ALU_ADD, 32'd7, 32'd8, 32'd0, 0, 5'd0, 1, 0, 1);
        cycle("rd0");
        check("rd0.reg_write_const", {31'b0, out_reg_write}, 32'd0);
        drive(1, 12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 5'd9, 1, 0, 1);
        cycle("op12");
        check("op12.const", out_result, 32'd0);

        // Back-pressure for three cycles, then drain and refill without a bubble.
        drive(1, ALU_ADD, 32'd1, 32'd2, 32'd0, 0, 5'd7, 1, 0, 1);
        cycle("bp_load");
        stall0 = m_stall;
        drive(1, ALU_ADD, 32'd10, 32'd20, 32'd0, 0, 5'd8, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp_hold.result_const", out_result, 32'd3);
            check("bp_hold.in_ready_const", {31'b0, in_ready}, 32'd0);
        end
        check("bp.stall_delta", stall_cnt, stall0 + 32'd3);
        out_ready = 1'b1;
        cycle("bp_release");
        check("bp_release.result_const", out_result, 32'd30);
        check("bp_release.rd_const", {27'b0, out_rd}, 32'd8);
        drive(1, ALU_SUB, 32'd1, 32'd2, 32'd0, 0, 5'd9, 1, 0, 1);
        cycle("bp_next");
        check("bp_next.result_const", out_result, 32'hFFFF_FFFF);

        // Flush while holding a result and presenting a new instruction.
        drive(1, ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 0, 5'd10, 1, 1, 1);
        cycle("flush");
        check("flush.valid_const", {31'b0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("flush_after");
        check("flush_after.valid_const", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset pulse between edges.
        drive(1, ALU_OR, 32'h0F00, 32'h00F0, 32'd0, 0, 5'd11, 1, 0, 1);
        cycle("prerst_load");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("prerst_stall");
        rst_n = 1'b0;
        #2;
        model_reset();
        check("async_rst.valid", {31'b0, out_valid}, 32'd0);
        check("async_rst.stall", stall_cnt, 32'd0);
        check("async_rst.result", out_result, 32'd0);
        rst_n = 1'b1;
        drive(1, ALU_AND, 32'hFF, 32'h0F, 32'd0, 0, 5'd12, 1, 0, 1);
        cycle("postrst");

        // Reset held across an edge: nothing is accepted.
        rst_n = 1'b0;
        drive(1, ALU_ADD, 32'd1, 32'd1, 32'd0, 0, 5'd13, 1, 0, 1);
        cycle("rst_hold");
        rst_n = 1'b1;
        cycle("rst_release");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b2, im;
            logic [4:0]  rd;
            a  = $urandom;
            b2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            im = $urandom;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), a, b2, im,
                  $urandom_range(0, 1) == 1, rd, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  ex_stage accepts the instruction this cycle.
REQ-006 alu_ctrl  input  4  ALU operation code from the ALU decoder.
REQ-007 rs1_data  input  XLEN  operand A.
REQ-008 rs2_data  input  XLEN  register operand B and store data.
REQ-009 imm  input  XLEN  sign-extended immediate.
REQ-010 alu_src  input  1  1 selects imm as operand B; 0 selects rs2_data.
REQ-011 rd_addr  input  5  destination register.
REQ-012 reg_write  input  1  instruction writes rd.
REQ-013 flush  input  1  kill the held result and any incoming instruction.
REQ-014 out_valid  output  1  result register holds a valid instruction.
REQ-015 out_ready  input  1  memory stage accepts the result.
REQ-016 out_result  output  XLEN  registered ALU result.
REQ-017 out_rs2_data  output  XLEN  registered rs2_data.
REQ-018 out_rd  output  5  registered rd_addr.
REQ-019 out_reg_write  output  1  registered write enable.
REQ-020 stall_cnt  output  32  count of back-pressure cycles.

Function
REQ-021 ALU codes: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1); codes 10-15 produce 0.
REQ-022 Shift amount is operand B[4:0]; the upper bits are ignored; ADD and SUB wrap modulo 2^32.
REQ-023 in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-024 Accept = in_valid && in_ready && !flush; on accept, the next edge loads the ALU result, rs2_data, rd_addr, and reg_write && (rd_addr != 0), and sets out_valid=1.
REQ-025 Latency: result is visible exactly one cycle after acceptance; throughput is one instruction per cycle when out_ready is held high.
REQ-026 out_valid && out_ready && !accept clears out_valid at the next edge.
REQ-027 When out_valid && !out_ready, all out_* hold stable and no input is accepted.
REQ-028 flush has priority over all other events: the next edge sets out_valid=0 and out_reg_write=0, and the incoming instruction is dropped; data registers are don't-care.
REQ-029 stall_cnt increments by 1 on every cycle with out_valid && !out_ready; it wraps from 0xFFFFFFFF to 0; flush does not clear it.
REQ-030 Simultaneous drain and accept (out_valid && out_ready && accept) replaces the held result without a bubble.

Reset
REQ-031 Asserting rst_n low asynchronously clears out_valid, out_reg_write, out_result, out_rs2_data, out_rd, and stall_cnt to 0.
REQ-032 Reset asserted mid-transfer discards the held instruction; in_ready is 1 from the first cycle after release.
REQ-033 Deassertion of rst_n takes effect at a clock edge; no instruction is accepted in the cycle rst_n is low.

Structure
REQ-034 ALU code constants (ALU_ADD to ALU_SLTU) live in shared package ex_pkg, which is also used by the ALU decoder.
REQ-035 The combinational ALU is a sub-module named alu (ports: alu_ctrl, a, b, y); ex_stage contains operand select, pipeline register, handshake, and counter.

Verification
REQ-036 rs1=5, imm=0xFFFFFFFD, alu_src=1, ADD, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_result=2.
REQ-037 rs1=0x80000000, rs2=4, SRA, then SRL -> 0xF8000000, then 0x08000000; SLT with rs1=0xFFFFFFFF, rs2=1 -> 1; SLTU with the same operands -> 0.
REQ-038 Hold out_ready=0 for 3 cycles with a result held -> out_* stable, in_ready=0, stall_cnt increases by 3; release -> drains, then the next instruction follows with no bubble.
REQ-039 flush asserted in the same cycle as in_valid with out_valid=1 -> next cycle out_valid=0; the flushed instruction never appears.
REQ-040 reg_write=1 with rd_addr=0 -> out_reg_write=0; alu_ctrl=12 -> out_result=0.
REQ-041 rst_n pulsed low between edges while out_valid=1 -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.
